// File: rtl/dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : dds_phase_gen
// Purpose  : DDS phase accumulator producing waveform-table addresses over a
//            valid/ack handshake; a Mode change restarts the phase at zero.
//            Optional triangle output Tri is compiled in with DDS_TRI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dds_phase_gen #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 8
) (
    input  logic              Fg_clk,
    input  logic              Reset,
    input  logic              Ready,
    input  logic              Enable,
    input  logic [2:0]        Mode,
    input  logic [ACC_W-1:0]  Tune,
    input  logic              SampleAck,
    output logic [ADDR_W-1:0] SampleAddr,
    output logic              SampleValid,
    output logic              Wrap,
    output logic              Overrun
`ifdef DDS_TRI_EN
    ,
    output logic [ADDR_W-1:0] Tri
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_mode_q;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next_acc;
    logic             w_mode_chg;
    logic             w_step;

    assign w_sum      = {1'b0, r_acc} + {1'b0, Tune};
    assign w_next_acc = w_sum[ACC_W-1:0];
    assign w_mode_chg = (Mode != r_mode_q);

    // A step is taken from RUN, or from WAIT when the pending sample is acked.
    assign w_step = Enable && !w_mode_chg &&
                    ((r_state == ST_RUN) || ((r_state == ST_WAIT) && SampleAck));

`ifdef DDS_TRI_EN
    logic [ADDR_W-1:0] w_tri_field;
    logic [ADDR_W-1:0] w_tri_next;

    assign w_tri_field = w_next_acc[ACC_W-2 -: ADDR_W];
    assign w_tri_next  = w_next_acc[ACC_W-1] ? ~w_tri_field : w_tri_field;

    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            Tri <= '0;
        end else if ((r_state != ST_IDLE) && w_mode_chg) begin
            Tri <= '0;
        end else if (w_step) begin
            Tri <= w_tri_next;
        end
    end
`endif

    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_mode_q    <= 3'd0;
            SampleAddr  <= '0;
            SampleValid <= 1'b0;
            Wrap        <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Ready) begin
                        r_state  <= ST_RUN;
                        r_mode_q <= Mode;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (w_mode_chg) begin
                        r_acc       <= '0;
                        SampleAddr  <= '0;
                        SampleValid <= 1'b0;
                        r_mode_q    <= Mode;
                        r_state     <= ST_RUN;
                    end else if (w_step) begin
                        r_acc       <= w_next_acc;
                        SampleAddr  <= w_next_acc[ACC_W-1 -: ADDR_W];
                        Wrap        <= w_sum[ACC_W];
                        SampleValid <= 1'b1;
                        r_state     <= ST_WAIT;
                    end else if (r_state == ST_WAIT) begin
                        if (SampleAck) begin
                            SampleValid <= 1'b0;
                            r_state     <= ST_RUN;
                        end else if (Enable) begin
                            Overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_phase_gen
// Purpose  : Scoreboard bench for dds_phase_gen (ACC_W=24, ADDR_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_phase_gen;

    logic        Fg_clk = 1'b0;
    logic        Reset, Ready, Enable, SampleAck;
    logic [2:0]  Mode;
    logic [23:0] Tune;
    logic [7:0]  SampleAddr;
    logic        SampleValid, Wrap, Overrun;
`ifdef DDS_TRI_EN
    logic [7:0]  Tri;
`endif

    dds_phase_gen #(.ACC_W(24), .ADDR_W(8)) u_dut (
        .Fg_clk      (Fg_clk),
        .Reset       (Reset),
        .Ready       (Ready),
        .Enable      (Enable),
        .Mode        (Mode),
        .Tune        (Tune),
        .SampleAck   (SampleAck),
        .SampleAddr  (SampleAddr),
        .SampleValid (SampleValid),
        .Wrap        (Wrap),
        .Overrun     (Overrun)
`ifdef DDS_TRI_EN
        ,
        .Tri         (Tri)
`endif
    );

    always #5 Fg_clk = ~Fg_clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       valid;
        logic       wrap;
        logic       ovr;
        logic [7:0] tri_v;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_run;
    logic [23:0] m_acc;
    logic [2:0]  m_mode_q;
    logic [7:0]  m_addr, m_tri;
    logic        m_valid, m_wrap, m_ovr;
    logic [2:0]  cur_md;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [23:0] tn);
        logic [24:0] s;
        logic [7:0]  f;
        s       = {1'b0, m_acc} + {1'b0, tn};
        m_acc   = s[23:0];
        m_addr  = m_acc[23:16];
        m_wrap  = s[24];
        m_valid = 1'b1;
        f       = m_acc[22:15];
        m_tri   = m_acc[23] ? ~f : f;
    endtask

    task automatic cycle(input logic rst, input logic rdy, input logic en,
                         input logic [2:0] md, input logic [23:0] tn, input logic ack);
        exp_t e, o;
        Reset = rst; Ready = rdy; Enable = en; Mode = md; Tune = tn; SampleAck = ack;
        m_wrap = 1'b0;
        if (rst) begin
            m_run = 0; m_acc = '0; m_mode_q = '0; m_addr = '0;
            m_valid = 0; m_ovr = 0; m_tri = '0;
        end else if (!m_run) begin
            if (rdy) begin
                m_run = 1'b1;
                m_mode_q = md;
            end
        end else if (md != m_mode_q) begin
            m_acc = '0; m_addr = '0; m_valid = 0; m_tri = '0; m_mode_q = md;
        end else if (!m_valid) begin
            if (en) model_step(tn);
        end else if (ack && en) begin
            model_step(tn);
        end else if (ack) begin
            m_valid = 1'b0;
        end else if (en) begin
            m_ovr = 1'b1;
        end
        exp_q.push_back('{m_addr, m_valid, m_wrap, m_ovr, m_tri});
        @(posedge Fg_clk);
        #1;
        e = exp_q.pop_front();
        o.addr = SampleAddr; o.valid = SampleValid; o.wrap = Wrap; o.ovr = Overrun;
        check_val("addr",    {24'd0, o.addr}, {24'd0, e.addr});
        check_val("valid",   {31'd0, o.valid}, {31'd0, e.valid});
        check_val("wrap",    {31'd0, o.wrap},  {31'd0, e.wrap});
        check_val("overrun", {31'd0, o.ovr},   {31'd0, e.ovr});
`ifdef DDS_TRI_EN
        check_val("tri",     {24'd0, Tri},     {24'd0, e.tri_v});
`endif
    endtask

    initial begin
        cur_md = 3'd0;
        m_run = 0; m_acc = '0; m_mode_q = '0; m_addr = '0;
        m_valid = 0; m_wrap = 0; m_ovr = 0; m_tri = '0;

        cycle(1, 0, 0, 0, 24'h0, 0);
        cycle(1, 0, 0, 0, 24'h0, 0);
        check_val("rst_addr",  {24'd0, SampleAddr}, 32'h0);
        check_val("rst_valid", {31'd0, SampleValid}, 32'h0);

        // Enable without Ready must be ignored
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 24'h010000, 1);
            cycle(0, 0, 0, 0, 24'h010000, 1);
        end
        check_val("idle_addr", {24'd0, SampleAddr}, 32'h0);

        cycle(0, 1, 0, 0, 24'h0, 1);
        cycle(0, 0, 1, 0, 24'h010000, 1);
        check_val("ramp1", {24'd0, SampleAddr}, 32'h01);
        cycle(0, 0, 1, 0, 24'h010000, 1);
        check_val("ramp2", {24'd0, SampleAddr}, 32'h02);
        cycle(0, 0, 1, 0, 24'h010000, 1);
        check_val("ramp3", {24'd0, SampleAddr}, 32'h03);
        cycle(0, 0, 0, 0, 24'h0, 1);

        // Mode change re-zeroes phase before the wrap test
        cycle(0, 0, 0, 1, 24'h0, 1);
        cycle(0, 0, 1, 1, 24'h800000, 1);
        check_val("half_addr", {24'd0, SampleAddr}, 32'h80);
        check_val("half_wrap", {31'd0, Wrap}, 32'h0);
        cycle(0, 0, 1, 1, 24'h800000, 1);
        check_val("wrap_addr", {24'd0, SampleAddr}, 32'h00);
        check_val("wrap_flag", {31'd0, Wrap}, 32'h1);
        cycle(0, 0, 0, 1, 24'h0, 1);

        // Overrun: unacked step followed by another Enable
        cycle(0, 0, 0, 0, 24'h0, 0);
        cycle(0, 0, 1, 0, 24'h010000, 0);
        cycle(0, 0, 1, 0, 24'h010000, 0);
        check_val("ovr_hold", {24'd0, SampleAddr}, 32'h01);
        check_val("ovr_flag", {31'd0, Overrun}, 32'h1);
        cycle(0, 0, 1, 0, 24'h010000, 1);
        check_val("ovr_next", {24'd0, SampleAddr}, 32'h02);
        check_val("ovr_stky", {31'd0, Overrun}, 32'h1);

        // Mode change in WAIT at 0x05 with Enable asserted
        cycle(0, 0, 1, 0, 24'h030000, 1);
        check_val("pre_mode", {24'd0, SampleAddr}, 32'h05);
        cycle(0, 0, 1, 2, 24'h030000, 1);
        check_val("mode_addr",  {24'd0, SampleAddr}, 32'h00);
        check_val("mode_valid", {31'd0, SampleValid}, 32'h0);
        cycle(0, 0, 1, 2, 24'h030000, 0);
        check_val("mode_step", {24'd0, SampleAddr}, 32'h03);

        // Reset in WAIT, then Enable without Ready
        cycle(1, 0, 1, 2, 24'h030000, 0);
        check_val("rstw_ovr", {31'd0, Overrun}, 32'h0);
        cycle(0, 0, 1, 2, 24'h030000, 1);
        check_val("rstw_idle", {31'd0, SampleValid}, 32'h0);

        // Triangle path: two acked steps of 0xC00000
        cycle(0, 1, 0, 0, 24'h0, 1);
        cycle(0, 0, 1, 0, 24'hC00000, 1);
        cycle(0, 0, 1, 0, 24'hC00000, 1);
        cycle(0, 0, 0, 0, 24'h0, 1);

        // Randomised traffic against the model
        cur_md = 3'd0;
        for (int i = 0; i < 400; i++) begin
            logic [23:0] tn;
            if ($urandom_range(0, 24) == 0) cur_md = 3'($urandom_range(0, 4));
            tn = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 24'h0FFFFF));
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), cur_md, tn, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
